// File: rtl/fifo_buffer_pkg.sv
// Shared defaults and helpers for the fifo_buffer block and the stages that
// instantiate it alongside the per-bit register stage.
package fifo_buffer_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_DEPTH     = 8;
    localparam int DEFAULT_AFULL_LVL = 6;

    // Pointer width for a given depth; depth is at least 2 so this is >= 1.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// Circular FIFO pointer: advances on inc and wraps from DEPTH-1 back to 0,
// so depths that are not a power of two work without modulo arithmetic.
module fifo_ptr #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock FIFO with registered read data, occupancy count, full/empty/
// almost_full decode and sticky overflow/underflow flags.
module fifo_buffer
    import fifo_buffer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AFULL_LVL = DEFAULT_AFULL_LVL,
    localparam int AW       = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW + 1)'(AFULL_LVL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    logic [AW:0]      count_q,    count_d;
    logic [WIDTH-1:0] rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    err_flags_t       err_q,      err_d;

    // Flags come straight from the registered count, so they never lag it.
    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AFULL_CNT);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        err_d      = err_q;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (rd_acc) begin
            rd_data_d = mem[rd_ptr];
        end

        // A fresh error in the clearing cycle keeps its flag set.
        err_d.overflow  = (err_q.overflow  & ~clr_err) | (wr_en & full);
        err_d.underflow = (err_q.underflow & ~clr_err) | (rd_en & empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // already mark it empty, and a reset-free array maps onto plain RAM.
    // Writes are still blocked while reset is held.
    always_ff @(posedge clk) begin
        if (wr_acc && reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign count     = count_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;

endmodule
